fp_mac_pipeline: RTL

//  Pipelined single-precision FP arithmetic unit for the neuron-update datapath (v' = decay*v + gain*I).

---
 rtl/fp_mac_pipeline.sv | 276 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/fp_mac_pipeline.sv
// rtl/fp_mac_pipeline.sv - 3-stage pipelined single-precision ADD/SUB/MUL/MAC/MSC unit with tag and flags
//
// Purpose : v' = decay*v + gain*I style datapath. S1 registers the op, S2 registers the product
//           (MUL/MAC/MSC) or A (ADD/SUB) plus the addend, S3 registers the final result.
//           One op per cycle; a stalled output freezes every stage.
// Ports   : CLK, RESETN (async, active-low)
//           in_valid/in_ready, in_op (0 ADD 1 SUB 2 MUL 3 MAC 4 MSC, 5..7 reserved -> qNaN),
//           in_a/in_b/in_c (IEEE-754 single), in_tag
//           out_valid/out_ready, out_result, out_tag, out_flags ([0] NaN/Inf [1] overflow [2] underflow)
//           flags_clr, sticky_flags
// Macro   : FP_STICKY_FLAGS_EN - when defined, sticky_flags accumulates out_flags of accepted results
//           and flags_clr clears it; otherwise sticky_flags is 3'b000.
// Rounding is round-to-nearest-even; results below the normal range flush to signed zero.
module fp_mac_pipeline #(
   parameter int TAG_W        = 5,
   parameter bit FLUSH_DENORM = 1'b1
) (
   input  logic             CLK,
   input  logic             RESETN,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       in_op,
   input  logic [31:0]      in_a,
   input  logic [31:0]      in_b,
   input  logic [31:0]      in_c,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_result,
   output logic [TAG_W-1:0] out_tag,
   output logic [2:0]       out_flags,
   input  logic             flags_clr,
   output logic [2:0]       sticky_flags
);
   localparam logic [31:0] QNAN   = 32'h7FC00000;
   localparam logic [2:0]  OP_SUB = 3'd1;
   localparam logic [2:0]  OP_MUL = 3'd2;
   localparam logic [2:0]  OP_MAC = 3'd3;
   localparam logic [2:0]  OP_MSC = 3'd4;

   typedef struct packed {
      logic        sign;
      logic [8:0]  exp;    // biased; denormals use 1 with a clear hidden bit
      logic [23:0] man;    // includes hidden bit
      logic        zero;
      logic        inf;
      logic        nan;
   } unpacked_t;

   typedef struct packed {
      logic [31:0] val;
      logic [2:0]  flags;
   } fpres_t;

   function automatic unpacked_t unpack(input logic [31:0] x);
      unpacked_t u;
      u.sign = x[31];
      u.exp  = (x[30:23] == 8'd0) ? 9'd1 : {1'b0, x[30:23]};
      u.man  = {x[30:23] != 8'd0, x[22:0]};
      u.zero = (x[30:23] == 8'd0) && (FLUSH_DENORM || (x[22:0] == 23'd0));
      u.inf  = (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
      u.nan  = (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
      if (u.zero) u.man = 24'd0;
      return u;
   endfunction

   // m_in carries the magnitude with its binary point just below bit 48, scaled by 2^(e_in-127).
   function automatic fpres_t round_pack(input logic s, input logic signed [11:0] e_in,
                                         input logic [49:0] m_in);
      fpres_t             r;
      logic [49:0]        m;
      logic signed [11:0] e;
      logic [24:0]        rm;
      logic [5:0]         lead;
      logic [5:0]         sh;
      logic               found;
      logic               inc;
      m       = m_in;
      e       = e_in;
      r.flags = 3'b000;
      r.val   = {s, 31'd0};
      found   = 1'b0;
      lead    = 6'd0;
      for (int i = 0; i < 50; i++) begin
         if (m[i]) begin
            found = 1'b1;
            lead  = 6'(i);
         end
      end
      if (found) begin
         if (lead == 6'd49) begin
            m = {1'b0, m[49:2], m[1] | m[0]};   // keep the shifted-out bit as sticky
            e = e + 12'sd1;
         end else begin
            sh = 6'd48 - lead;
            m  = m << sh;
            e  = e - $signed({6'd0, sh});
         end
         inc = m[24] & (m[25] | (|m[23:0]));
         rm  = {1'b0, m[48:25]} + {24'd0, inc};
         if (rm[24]) begin
            e  = e + 12'sd1;
            rm = {1'b0, rm[24:1]};
         end
         if (e >= 12'sd255) begin
            r.val   = {s, 8'hFF, 23'd0};
            r.flags = 3'b010;
         end else if (e <= 12'sd0) begin
            r.val   = {s, 31'd0};
            r.flags = 3'b100;
         end else begin
            r.val   = {s, e[7:0], rm[22:0]};
         end
      end
      return r;
   endfunction

   function automatic fpres_t fp_mul(input logic [31:0] a, input logic [31:0] b);
      unpacked_t   ua;
      unpacked_t   ub;
      fpres_t      r;
      logic [47:0] p;
      logic        s;
      ua = unpack(a);
      ub = unpack(b);
      s  = ua.sign ^ ub.sign;
      p  = 48'd0;
      if (ua.nan || ub.nan || (ua.inf && ub.zero) || (ub.inf && ua.zero)) begin
         r.val = QNAN;
         r.flags = 3'b001;
      end else if (ua.inf || ub.inf) begin
         r.val = {s, 8'hFF, 23'd0};
         r.flags = 3'b001;
      end else if (ua.zero || ub.zero) begin
         r.val = {s, 31'd0};        // zero bypass, multiplier result unused
         r.flags = 3'b000;
      end else begin
         p = ua.man * ub.man;
         r = round_pack(s, $signed({3'b000, ua.exp}) + $signed({3'b000, ub.exp}) - 12'sd127,
                        {p, 2'b00});
      end
      return r;
   endfunction

   function automatic fpres_t fp_add(input logic [31:0] a, input logic [31:0] b_in, input logic sub);
      unpacked_t   ua;
      unpacked_t   ub;
      unpacked_t   ut;
      fpres_t      r;
      logic [31:0] b;
      logic [49:0] mx;
      logic [49:0] my;
      logic [49:0] sh;
      logic [8:0]  d;
      b       = {b_in[31] ^ sub, b_in[30:0]};
      ua      = unpack(a);
      ub      = unpack(b);
      ut      = ua;
      r.flags = 3'b000;
      if (ua.nan || ub.nan || (ua.inf && ub.inf && (ua.sign != ub.sign))) begin
         r.val = QNAN;
         r.flags = 3'b001;
      end else if (ua.inf || ub.inf) begin
         r.val = ua.inf ? a : b;
         r.flags = 3'b001;
      end else if (ua.zero && ub.zero) begin
         r.val = {ua.sign & ub.sign, 31'd0};
      end else if (ua.zero) begin
         r.val = b;
      end else if (ub.zero) begin
         r.val = a;
      end else begin
         if ({ub.exp, ub.man} > {ua.exp, ua.man}) begin
            ut = ua;
            ua = ub;
            ub = ut;
         end
         d  = ua.exp - ub.exp;
         mx = {1'b0, ua.man, 25'd0};
         my = {1'b0, ub.man, 25'd0};
         sh = my >> d;
         my = {sh[49:1], sh[0] | ((sh << d) != my)};
         mx = (ua.sign == ub.sign) ? (mx + my) : (mx - my);
         r  = round_pack((mx == 50'd0) ? 1'b0 : ua.sign, $signed({3'b000, ua.exp}), mx);
      end
      return r;
   endfunction

   logic             r_s1_valid, r_s2_valid, r_s3_valid;
   logic [2:0]       r_s1_op, r_s2_op;
   logic [31:0]      r_s1_a, r_s1_b, r_s1_c, r_s2_x, r_s2_y, r_s3_result;
   logic [TAG_W-1:0] r_s1_tag, r_s2_tag, r_s3_tag;
   logic [2:0]       r_s2_flags, r_s3_flags;
   logic             w_stall;
   fpres_t           w_mul, w_add;
   logic [31:0]      w_s2_x, w_s2_y, w_s3_val;
   logic [2:0]       w_s2_flags, w_s3_flags;

   assign w_stall    = r_s3_valid && !out_ready;
   assign in_ready   = RESETN && !w_stall;
   assign out_valid  = r_s3_valid;
   assign out_result = r_s3_result;
   assign out_tag    = r_s3_tag;
   assign out_flags  = r_s3_flags;

   always_comb begin
      w_mul      = fp_mul(r_s1_a, r_s1_b);
      w_s2_x     = r_s1_a;
      w_s2_y     = r_s1_b;
      w_s2_flags = 3'b000;
      if ((r_s1_op == OP_MUL) || (r_s1_op == OP_MAC) || (r_s1_op == OP_MSC)) begin
         w_s2_x     = w_mul.val;
         w_s2_y     = r_s1_c;
         w_s2_flags = w_mul.flags;
      end
   end

   always_comb begin
      w_add      = fp_add(r_s2_x, r_s2_y, (r_s2_op == OP_SUB) || (r_s2_op == OP_MSC));
      w_s3_val   = w_add.val;
      w_s3_flags = w_add.flags | r_s2_flags;
      if (r_s2_op == OP_MUL) begin
         w_s3_val   = r_s2_x;
         w_s3_flags = r_s2_flags;
      end else if (r_s2_op > OP_MSC) begin
         w_s3_val   = QNAN;
         w_s3_flags = 3'b001;
      end
   end

   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         r_s1_valid <= 1'b0;  r_s1_op <= 3'd0;  r_s1_tag <= '0;
         r_s1_a <= 32'd0;     r_s1_b <= 32'd0;  r_s1_c <= 32'd0;
         r_s2_valid <= 1'b0;  r_s2_op <= 3'd0;  r_s2_tag <= '0;
         r_s2_x <= 32'd0;     r_s2_y <= 32'd0;  r_s2_flags <= 3'd0;
         r_s3_valid <= 1'b0;  r_s3_result <= 32'd0;
         r_s3_tag <= '0;      r_s3_flags <= 3'd0;
      end else if (!w_stall) begin
         r_s1_valid  <= in_valid;
         r_s1_op     <= in_op;
         r_s1_tag    <= in_tag;
         r_s1_a      <= in_a;
         r_s1_b      <= in_b;
         r_s1_c      <= in_c;
         r_s2_valid  <= r_s1_valid;
         r_s2_op     <= r_s1_op;
         r_s2_tag    <= r_s1_tag;
         r_s2_x      <= w_s2_x;
         r_s2_y      <= w_s2_y;
         r_s2_flags  <= w_s2_flags;
         r_s3_valid  <= r_s2_valid;
         r_s3_result <= w_s3_val;
         r_s3_tag    <= r_s2_tag;
         r_s3_flags  <= w_s3_flags;
      end
   end

`ifdef FP_STICKY_FLAGS_EN
   logic [2:0] r_sticky;
   // A clear and a new flag in the same cycle: the new flag survives.
   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         r_sticky <= 3'b000;
      end else begin
         r_sticky <= (flags_clr ? 3'b000 : r_sticky) |
                     ((r_s3_valid && out_ready) ? r_s3_flags : 3'b000);
      end
   end
   assign sticky_flags = r_sticky;
`else
   logic w_unused_clr;
   assign w_unused_clr = flags_clr;
   assign sticky_flags = 3'b000;
`endif
endmodule
